// File: rtl/ysyx_22050710_axil_decoder_1x2.sv
// AXI-lite 1-to-2 address decoder: one upstream initiator, responders S0/S1, independent read/write FSMs.
// Optional AXIL_DEC_DECERR_EN: unmapped addresses answer DECERR locally instead of defaulting to S1.
module ysyx_22050710_axil_decoder_1x2 #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = ADDR_WIDTH'(32'hF000_0000),
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(32'hA000_0000),
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = ADDR_WIDTH'(32'hF000_0000)
) (
  input  logic                  i_aclk,
  input  logic                  i_arsetn,
  // upstream
  input  logic                  i_awvalid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [2:0]            i_awprot,
  output logic                  o_awready,
  input  logic                  i_wvalid,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  output logic                  o_wready,
  output logic                  o_bvalid,
  output logic [1:0]            o_bresp,
  input  logic                  i_bready,
  input  logic                  i_arvalid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [2:0]            i_arprot,
  output logic                  o_arready,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  input  logic                  i_rready,
  // responder S0
  output logic                  o_s0_awvalid,
  output logic [ADDR_WIDTH-1:0] o_s0_awaddr,
  output logic [2:0]            o_s0_awprot,
  input  logic                  i_s0_awready,
  output logic                  o_s0_wvalid,
  output logic [DATA_WIDTH-1:0] o_s0_wdata,
  output logic [STRB_WIDTH-1:0] o_s0_wstrb,
  input  logic                  i_s0_wready,
  input  logic                  i_s0_bvalid,
  input  logic [1:0]            i_s0_bresp,
  output logic                  o_s0_bready,
  output logic                  o_s0_arvalid,
  output logic [ADDR_WIDTH-1:0] o_s0_araddr,
  output logic [2:0]            o_s0_arprot,
  input  logic                  i_s0_arready,
  input  logic                  i_s0_rvalid,
  input  logic [DATA_WIDTH-1:0] i_s0_rdata,
  input  logic [1:0]            i_s0_rresp,
  output logic                  o_s0_rready,
  // responder S1
  output logic                  o_s1_awvalid,
  output logic [ADDR_WIDTH-1:0] o_s1_awaddr,
  output logic [2:0]            o_s1_awprot,
  input  logic                  i_s1_awready,
  output logic                  o_s1_wvalid,
  output logic [DATA_WIDTH-1:0] o_s1_wdata,
  output logic [STRB_WIDTH-1:0] o_s1_wstrb,
  input  logic                  i_s1_wready,
  input  logic                  i_s1_bvalid,
  input  logic [1:0]            i_s1_bresp,
  output logic                  o_s1_bready,
  output logic                  o_s1_arvalid,
  output logic [ADDR_WIDTH-1:0] o_s1_araddr,
  output logic [2:0]            o_s1_arprot,
  input  logic                  i_s1_arready,
  input  logic                  i_s1_rvalid,
  input  logic [DATA_WIDTH-1:0] i_s1_rdata,
  input  logic [1:0]            i_s1_rresp,
  output logic                  o_s1_rready
);

  // S0 wins on overlap; anything that misses S0 is routed to S1.
  function automatic logic dec_s1(input logic [ADDR_WIDTH-1:0] a);
    if ((a & S0_MASK) == S0_BASE) return 1'b0;
    if ((a & S1_MASK) == S1_BASE) return 1'b1;
    return 1'b1;
  endfunction

`ifdef AXIL_DEC_DECERR_EN
  function automatic logic dec_hit(input logic [ADDR_WIDTH-1:0] a);
    return ((a & S0_MASK) == S0_BASE) || ((a & S1_MASK) == S1_BASE);
  endfunction
`endif

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
`ifdef AXIL_DEC_DECERR_EN
    R_DATA,
    R_ERR
`else
    R_DATA
`endif
  } rd_state_e;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_ISSUE,
`ifdef AXIL_DEC_DECERR_EN
    W_RESP,
    W_ERR
`else
    W_RESP
`endif
  } wr_state_e;

  // ---------------- read path ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [2:0]            ar_prot_q, ar_prot_d;
  logic                  ar_sel_q, ar_sel_d;
  logic                  arready_q, arready_d;

  logic                  sel_arvalid, sel_rready;
  logic                  sel_arready, sel_rvalid;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [1:0]            sel_rresp;

  assign sel_arready = ar_sel_q ? i_s1_arready : i_s0_arready;
  assign sel_rvalid  = ar_sel_q ? i_s1_rvalid  : i_s0_rvalid;
  assign sel_rdata   = ar_sel_q ? i_s1_rdata   : i_s0_rdata;
  assign sel_rresp   = ar_sel_q ? i_s1_rresp   : i_s0_rresp;

  always_comb begin
    rd_state_d  = rd_state_q;
    ar_addr_d   = ar_addr_q;
    ar_prot_d   = ar_prot_q;
    ar_sel_d    = ar_sel_q;
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    o_rvalid    = 1'b0;
    o_rdata     = '0;
    o_rresp     = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (i_arvalid && arready_q) begin
          ar_addr_d  = i_araddr;
          ar_prot_d  = i_arprot;
          ar_sel_d   = dec_s1(i_araddr);
          rd_state_d = R_ADDR;
`ifdef AXIL_DEC_DECERR_EN
          if (!dec_hit(i_araddr)) rd_state_d = R_ERR;
`endif
        end
      end
      R_ADDR: begin
        sel_arvalid = 1'b1;
        if (sel_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        o_rvalid   = sel_rvalid;
        o_rdata    = sel_rdata;
        o_rresp    = sel_rresp;
        sel_rready = i_rready;
        if (sel_rvalid && i_rready) rd_state_d = R_IDLE;
      end
`ifdef AXIL_DEC_DECERR_EN
      R_ERR: begin
        o_rvalid = 1'b1;
        o_rresp  = 2'b11;
        if (i_rready) rd_state_d = R_IDLE;
      end
`endif
      default: rd_state_d = R_IDLE;
    endcase
    // Registered ready: high in any cycle the FSM sits in R_IDLE.
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      ar_prot_q  <= '0;
      ar_sel_q   <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_prot_q  <= ar_prot_d;
      ar_sel_q   <= ar_sel_d;
      arready_q  <= arready_d;
    end
  end

  // ---------------- write path ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]            aw_prot_q, aw_prot_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;

  logic                  sel_awvalid, sel_wvalid, sel_bready;
  logic                  sel_awready, sel_wready, sel_bvalid;
  logic [1:0]            sel_bresp;

  assign sel_awready = wr_sel_q ? i_s1_awready : i_s0_awready;
  assign sel_wready  = wr_sel_q ? i_s1_wready  : i_s0_wready;
  assign sel_bvalid  = wr_sel_q ? i_s1_bvalid  : i_s0_bvalid;
  assign sel_bresp   = wr_sel_q ? i_s1_bresp   : i_s0_bresp;

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_addr_d   = aw_addr_q;
    aw_prot_d   = aw_prot_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    wr_sel_d    = wr_sel_q;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    o_bvalid    = 1'b0;
    o_bresp     = '0;
    case (wr_state_q)
      W_COLLECT: begin
        if (i_awvalid && awready_q) begin
          aw_addr_d = i_awaddr;
          aw_prot_d = i_awprot;
          aw_held_d = 1'b1;
        end
        if (i_wvalid && wready_q) begin
          w_data_d = i_wdata;
          w_strb_d = i_wstrb;
          w_held_d = 1'b1;
        end
        // Decode from the captured address one cycle after both halves are held.
        if (aw_held_q && w_held_q) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_sel_d   = dec_s1(aw_addr_q);
          wr_state_d = W_ISSUE;
`ifdef AXIL_DEC_DECERR_EN
          if (!dec_hit(aw_addr_q)) wr_state_d = W_ERR;
`endif
        end
      end
      W_ISSUE: begin
        sel_awvalid = !aw_done_q;
        sel_wvalid  = !w_done_q;
        if (sel_awvalid && sel_awready) aw_done_d = 1'b1;
        if (sel_wvalid && sel_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        o_bvalid   = sel_bvalid;
        o_bresp    = sel_bresp;
        sel_bready = i_bready;
        if (sel_bvalid && i_bready) wr_state_d = W_COLLECT;
      end
`ifdef AXIL_DEC_DECERR_EN
      W_ERR: begin
        o_bvalid = 1'b1;
        o_bresp  = 2'b11;
        if (i_bready) wr_state_d = W_COLLECT;
      end
`endif
      default: wr_state_d = W_COLLECT;
    endcase
    awready_d = (wr_state_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == W_COLLECT) && !w_held_d;
  end

  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      wr_state_q <= W_COLLECT;
      aw_addr_q  <= '0;
      aw_prot_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wr_sel_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_prot_q  <= aw_prot_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wr_sel_q   <= wr_sel_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
    end
  end

  // ---------------- output fan-out ----------------
  assign o_arready    = arready_q;
  assign o_awready    = awready_q;
  assign o_wready     = wready_q;

  assign o_s0_arvalid = sel_arvalid & ~ar_sel_q;
  assign o_s1_arvalid = sel_arvalid &  ar_sel_q;
  assign o_s0_rready  = sel_rready  & ~ar_sel_q;
  assign o_s1_rready  = sel_rready  &  ar_sel_q;
  assign o_s0_araddr  = ar_addr_q;
  assign o_s1_araddr  = ar_addr_q;
  assign o_s0_arprot  = ar_prot_q;
  assign o_s1_arprot  = ar_prot_q;

  assign o_s0_awvalid = sel_awvalid & ~wr_sel_q;
  assign o_s1_awvalid = sel_awvalid &  wr_sel_q;
  assign o_s0_wvalid  = sel_wvalid  & ~wr_sel_q;
  assign o_s1_wvalid  = sel_wvalid  &  wr_sel_q;
  assign o_s0_bready  = sel_bready  & ~wr_sel_q;
  assign o_s1_bready  = sel_bready  &  wr_sel_q;
  assign o_s0_awaddr  = aw_addr_q;
  assign o_s1_awaddr  = aw_addr_q;
  assign o_s0_awprot  = aw_prot_q;
  assign o_s1_awprot  = aw_prot_q;
  assign o_s0_wdata   = w_data_q;
  assign o_s1_wdata   = w_data_q;
  assign o_s0_wstrb   = w_strb_q;
  assign o_s1_wstrb   = w_strb_q;

endmodule
